// File: rtl/rx2in_ctl.sv
// UART RX to CPU INBOX bridge: buffers received bytes in a small FIFO and
// forwards them one per three clocks while the INBOX reports not-full.
module rx2in_ctl #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          i_rst,
    input  logic          i_wr,
    input  logic [7:0]    i_data,
    input  logic          i_full_n,
    input  logic          i_clr_ovf,
    output logic          o_wr,
    output logic [7:0]    o_data,
    output logic [AW:0]   o_level,
    output logic          o_overflow,
    output logic [7:0]    o_drop_cnt
);

    typedef enum logic [1:0] {IDLE, WRITE, SETTLE} state_t;

    localparam logic [AW:0] LEVEL_MAX = (AW+1)'(DEPTH);

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;
    logic          push;
    logic          drop;

    // A pop on this edge frees a slot, so a push into a full FIFO still fits.
    always_comb begin
        pop  = (state == IDLE) && (o_level != '0) && i_full_n;
        push = i_wr && ((o_level < LEVEL_MAX) || pop);
        drop = i_wr && !push;
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_level    <= '0;
            o_wr       <= 1'b0;
            o_data     <= '0;
            o_overflow <= 1'b0;
            o_drop_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);

            case ({push, pop})
                2'b10:   o_level <= o_level + (AW+1)'(1);
                2'b01:   o_level <= o_level - (AW+1)'(1);
                default: o_level <= o_level;
            endcase

            case (state)
                IDLE: begin
                    if (pop) begin
                        o_data <= mem[rd_ptr];
                        o_wr   <= 1'b1;
                        state  <= WRITE;
                    end
                end
                WRITE: begin
                    o_wr  <= 1'b0;
                    state <= SETTLE;
                end
                SETTLE:  state <= IDLE;
                default: state <= IDLE;
            endcase

            // A drop on the clearing edge wins and counts as the first loss.
            if (i_clr_ovf) begin
                o_overflow <= drop;
                o_drop_cnt <= drop ? 8'd1 : 8'd0;
            end else if (drop) begin
                o_overflow <= 1'b1;
                if (o_drop_cnt != 8'hFF)
                    o_drop_cnt <= o_drop_cnt + 8'd1;
            end
        end
    end

    // NOTE: storage is left out of reset; the pointers and level alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= i_data;
    end

endmodule
